fp_add_sequencer: RTL and testbench
===================================

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from fp_pkg: FRACTION_BITS = 23, EXPONENT_BITS = 8, operand/result type float {sign, exp, frac}.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 a  input  32 (float)  operand A.
REQ-007 b  input  32 (float)  operand B.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  32 (float)  sum a+b.
REQ-011 busy  output  1  high whenever state != IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, CMP, ALIGN, ADD, NORM and DONE, each a registered state advancing on the rising clk edge.
REQ-013 in_ready SHALL equal (state == IDLE); an accept is in_valid && in_ready on a clk edge, which latches a and b and moves to CMP.
REQ-014 a and b SHALL be ignored outside an accept edge.
REQ-015 CMP (1 cycle) SHALL select big = the operand with larger {exp,frac}; on a tie big = a, small = b.
REQ-016 In CMP, if either operand has exp = 255, result SHALL be a if a.exp = 255, else b, and the FSM SHALL go to DONE.
REQ-017 In CMP, any operand with exp = 0 SHALL be treated as zero (no subnormals).
- Both zero: result = {a.sign & b.sign, 0, 0}, go to DONE.
- One zero: result = the other operand unchanged, go to DONE.
REQ-018 ALIGN (1 cycle) SHALL form the small significand {1, small.frac} (24 bits) and shift it right by big.exp - small.exp with truncation.
- Shift >= 24: aligned significand = 0.
- Working exponent = big.exp.
REQ-019 ADD (1 cycle) SHALL form a 25-bit sum.
- Equal signs: {1, big.frac} + aligned.
- Unequal signs: {1, big.frac} - aligned.
- Sign = big.sign.
REQ-020 If the ADD sum is zero, result SHALL be 0x00000000 and the FSM SHALL go directly to DONE (skip NORM).
REQ-021 NORM SHALL process one step per cycle:
- sum[24] = 1: shift right 1 and exp+1, then DONE.
- sum[23] = 1: DONE.
- Otherwise: shift left 1, exp-1, stay in NORM.
REQ-022 If exp reaches 255 in NORM, result SHALL be {sign, 255, 0} (infinity).
REQ-023 If exp reaches 0 before sum[23] = 1, result SHALL be {sign, 0, 0} (flush to zero).
REQ-024 Otherwise result SHALL be {sign, exp, sum[22:0]}.
REQ-025 Latency, counted from the accept edge to out_valid high:
- 5 cycles for a normalized or right-shift sum.
- 5 + n cycles for n left shifts, n <= 23.
- 4 cycles for a zero sum.
- 2 cycles for the CMP bypass cases.
REQ-026 In DONE, out_valid SHALL be 1 and result SHALL hold stable until an edge with out_ready = 1, after which the FSM SHALL go to IDLE.
- out_valid SHALL drop on that edge.
- No new accept SHALL occur on that same edge.
REQ-027 out_valid SHALL be 0 in every state other than DONE; result SHALL retain its last value outside DONE.

Reset
REQ-028 While rst_n = 0, the outputs SHALL be forced immediately (asynchronously), including mid-operation:
- state = IDLE;
- out_valid = 0, busy = 0, result = 0x00000000;
- all operand/working registers cleared;
- in_ready = 0.
REQ-029 On the first clk edge after rst_n rises, in_ready SHALL be 1; no result from an operation interrupted by reset SHALL ever appear.

Verification
REQ-030 The bench SHALL cover:
- a = 0x3F800000, b = 0x3F800000, out_ready = 1 -> result 0x40000000, out_valid 5 cycles after accept.
- a = 0x3F800000, b = 0xBF800000 -> result 0x00000000, out_valid 4 cycles after accept.
- a = 0x3FC00000, b = 0xBF800000 -> result 0x3F000000 after one left shift, out_valid 6 cycles after accept.
- a = 0x7F7FFFFF, b = 0x7F7FFFFF -> result 0x7F800000.
- Hold out_ready = 0 for 10 cycles in DONE while driving in_valid = 1 with new operands -> result stable, in_ready = 0, no accept; out_ready = 1 -> IDLE next edge.
- Assert rst_n = 0 during NORM -> out_valid = 0, busy = 0 and result = 0 immediately; after release, in_ready = 1 and the next accepted pair (0x3F800000 + 0x3F800000) returns 0x40000000.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer -- multi-cycle single-precision adder, one operation in flight.
//
// Purpose:
//   Adds two IEEE-754-style single-precision operands through a six-state FSM
//   (IDLE -> CMP -> ALIGN -> ADD -> NORM -> DONE). Alignment truncates, there
//   is no rounding, subnormal inputs are treated as zero, tiny results flush to
//   zero, and any operand with an all-ones exponent is passed through unchanged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair a/b present
//   in_ready   out  sequencer can accept an operand pair (IDLE only)
//   a, b       in   32-bit operands {sign, exp[7:0], frac[22:0]}
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   result     out  32-bit sum a+b, held until the next operation completes
//   busy       out  high whenever the FSM is not in IDLE

package fp_pkg;
  localparam int FRACTION_BITS = 23;
  localparam int EXPONENT_BITS = 8;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exp;
    logic [FRACTION_BITS-1:0] frac;
  } float_t;
endpackage

module fp_add_sequencer
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

  localparam int SIG_W = FRACTION_BITS + 1;
  localparam logic [EXPONENT_BITS-1:0] EXP_MAX = '1;
  localparam logic [EXPONENT_BITS+FRACTION_BITS-1:0] ZERO_MAG = '0;
  localparam logic [EXPONENT_BITS+FRACTION_BITS-1:0] INF_MAG =
    {EXP_MAX, {FRACTION_BITS{1'b0}}};

  state_t                   state_q, state_d;
  float_t                   a_q, a_d, b_q, b_d;
  float_t                   big_q, big_d, small_q, small_d;
  logic [EXPONENT_BITS-1:0] exp_q, exp_d;
  logic [SIG_W-1:0]         aligned_q, aligned_d;
  logic [SIG_W:0]           sum_q, sum_d, sum_add;
  float_t                   result_q, result_d;
  // Holds in_ready low until the first clock edge after reset is released.
  logic                     rdy_en_q;

  // Hidden-one significand shifted right with truncation; shifts of a full
  // significand width or more leave nothing.
  function automatic logic [SIG_W-1:0] align_sig(
    input logic [FRACTION_BITS-1:0] frac,
    input logic [EXPONENT_BITS-1:0] shift
  );
    logic [SIG_W-1:0] sig;
    sig = {1'b1, frac};
    if (shift >= EXPONENT_BITS'(SIG_W)) begin
      return '0;
    end
    return sig >> shift;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    big_d     = big_q;
    small_d   = small_q;
    exp_d     = exp_q;
    aligned_d = aligned_q;
    sum_d     = sum_q;
    result_d  = result_q;
    sum_add   = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          state_d = CMP;
        end
      end

      CMP: begin
        // Magnitude order on {exp,frac}; a wins ties so it becomes big.
        if ({a_q.exp, a_q.frac} >= {b_q.exp, b_q.frac}) begin
          big_d   = a_q;
          small_d = b_q;
        end else begin
          big_d   = b_q;
          small_d = a_q;
        end
        state_d = DONE;
        if (a_q.exp == EXP_MAX) begin
          result_d = a_q;
        end else if (b_q.exp == EXP_MAX) begin
          result_d = b_q;
        end else if (a_q.exp == '0 && b_q.exp == '0) begin
          result_d = {a_q.sign & b_q.sign, ZERO_MAG};
        end else if (a_q.exp == '0) begin
          result_d = b_q;
        end else if (b_q.exp == '0) begin
          result_d = a_q;
        end else begin
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        aligned_d = align_sig(small_q.frac, big_q.exp - small_q.exp);
        exp_d     = big_q.exp;
        state_d   = ADD;
      end

      ADD: begin
        // big >= small in magnitude, so the difference never goes negative.
        if (big_q.sign == small_q.sign) begin
          sum_add = {2'b01, big_q.frac} + {1'b0, aligned_q};
        end else begin
          sum_add = {2'b01, big_q.frac} - {1'b0, aligned_q};
        end
        sum_d = sum_add;
        if (sum_add == '0) begin
          result_d = '0;
          state_d  = DONE;
        end else begin
          state_d  = NORM;
        end
      end

      NORM: begin
        if (sum_q[SIG_W]) begin
          exp_d   = exp_q + 1'b1;
          state_d = DONE;
          if (exp_q == EXP_MAX - 1'b1) begin
            result_d = {big_q.sign, INF_MAG};
          end else begin
            result_d = {big_q.sign, exp_q + 1'b1, sum_q[SIG_W-1:1]};
          end
        end else if (sum_q[SIG_W-1]) begin
          result_d = {big_q.sign, exp_q, sum_q[FRACTION_BITS-1:0]};
          state_d  = DONE;
        end else begin
          exp_d = exp_q - 1'b1;
          sum_d = sum_q << 1;
          // This shift would take the exponent to zero before the leading
          // one is in place: the value is below the normal range.
          if (exp_q == EXPONENT_BITS'(1)) begin
            result_d = {big_q.sign, ZERO_MAG};
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      big_q     <= '0;
      small_q   <= '0;
      exp_q     <= '0;
      aligned_q <= '0;
      sum_q     <= '0;
      result_q  <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      big_q     <= big_d;
      small_q   <= small_d;
      exp_q     <= exp_d;
      aligned_q <= aligned_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign in_ready  = (state_q == IDLE) && rdy_en_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: directed cases plus randomized
// operand pairs, scored against an arithmetic reference model with a per-cycle
// compare process. Latency L means out_valid is first seen after the (L-1)th
// clock edge following the accept edge.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  fp_add_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    bit          known;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rel_edges = 0;
  logic [31:0] last_res = 32'h0;
  bit          ordy_rand = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on significands.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat, output bit known);
    logic [31:0] bg, sm;
    int eb, es, d, sb, ss, al, s, p, n, e;
    known = 1'b1;
    lat   = 2;
    if (x[30:23] == 8'hFF) begin r = x; return; end
    if (y[30:23] == 8'hFF) begin r = y; return; end
    if (x[30:23] == 8'h00 && y[30:23] == 8'h00) begin r = {x[31] & y[31], 31'b0}; return; end
    if (x[30:23] == 8'h00) begin r = y; return; end
    if (y[30:23] == 8'h00) begin r = x; return; end
    if (x[30:0] >= y[30:0]) begin bg = x; sm = y; end else begin bg = y; sm = x; end
    eb = int'(bg[30:23]);
    es = int'(sm[30:23]);
    d  = eb - es;
    sb = int'(bg[22:0]) + (1 << 23);
    ss = int'(sm[22:0]) + (1 << 23);
    al = (d >= 24) ? 0 : (ss >> d);
    s  = (bg[31] == sm[31]) ? sb + al : sb - al;
    if (s == 0) begin r = 32'h0; lat = 4; return; end
    p = 0;
    for (int i = 24; i >= 0; i--) if ((s >> i) & 1) begin p = i; break; end
    lat = 5;
    if (p == 24) begin
      e = eb + 1;
      if (e >= 255) r = {bg[31], 8'hFF, 23'h0};
      else          r = {bg[31], 8'(e), 23'((s >> 1) & 32'h7FFFFF)};
    end else begin
      n = 23 - p;
      e = eb - n;
      if (e <= 0) begin
        r = {bg[31], 31'b0};
        known = 1'b0;
      end else begin
        r   = {bg[31], 8'(e), 23'((s << n) & 32'h7FFFFF)};
        lat = 5 + n;
      end
    end
  endfunction

  // Accept / handshake monitor: values seen here are those just before the edge.
  initial forever begin
    exp_t e;
    logic [31:0] r;
    int l;
    bit k;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      sb_q.delete();
      last_res  = 32'h0;
      rel_edges = 0;
    end else begin
      rel_edges++;
      if (out_valid && out_ready && sb_q.size() > 0) begin
        last_res = sb_q[0].res;
        void'(sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(a, b, r, l, k);
        e.res = r; e.lat = l; e.known = k; e.acc = cyc;
        sb_q.push_back(e);
      end
    end
  end

  // Per-cycle compare process.
  initial forever begin
    int age;
    @(negedge clk);
    if (cyc > 0) begin
      if (!rst_n) begin
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'h0);
        chk("rst_result",    result,             32'h0);
      end else begin
        chk("busy", {31'b0, busy}, {31'b0, sb_q.size() != 0});
        if (rel_edges >= 1) chk("in_ready", {31'b0, in_ready}, {31'b0, sb_q.size() == 0});
        if (sb_q.size() != 0) begin
          age = cyc - sb_q[0].acc + 1;
          if (sb_q[0].known) chk("out_valid_timing", {31'b0, out_valid}, {31'b0, age >= sb_q[0].lat});
          if (out_valid) chk("result", result, sb_q[0].res);
          else           chk("result_retained", result, last_res);
          if (age > 100) begin
            chk("op_stuck", {31'b0, out_valid}, 32'h1);
            void'(sb_q.pop_front());
          end
        end else begin
          chk("out_valid_idle", {31'b0, out_valid}, 32'h0);
          chk("result_retained", result, last_res);
        end
      end
    end
  end

  always @(negedge clk) if (ordy_rand) out_ready = 1'($urandom_range(0, 1));

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", {31'b0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb_q.size() != 0) && n < 200);
    if (busy) chk("drain_timeout", {31'b0, busy}, 32'h0);
  endtask

  function automatic logic [31:0] gen_op(input logic [31:0] r0, input int kind);
    logic [31:0] v;
    int e;
    v = $urandom;
    case (kind)
      1: begin
        e = int'(r0[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        v = {~r0[31], 8'(e), r0[22:0] ^ (23'd1 << $urandom_range(0, 22))};
      end
      2: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
      3: begin v[30:23] = 8'(250 + $urandom_range(0, 4)); v[31] = r0[31]; end
      4: v[30:23] = 8'($urandom_range(1, 4));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] x, y;
    int l, kx;
    bit k;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;

    // Hand-computed pins on the reference model itself.
    model(32'h3F800000, 32'h3F800000, r, l, k);
    chk("pin_1p1_res", r, 32'h40000000); chk("pin_1p1_lat", l, 5);
    model(32'h3F800000, 32'hBF800000, r, l, k);
    chk("pin_cancel_res", r, 32'h0); chk("pin_cancel_lat", l, 4);
    model(32'h3FC00000, 32'hBF800000, r, l, k);
    chk("pin_lshift_res", r, 32'h3F000000); chk("pin_lshift_lat", l, 6);
    model(32'h7F7FFFFF, 32'h7F7FFFFF, r, l, k);
    chk("pin_ovf_res", r, 32'h7F800000);
    model(32'h7F800000, 32'h3F800000, r, l, k);
    chk("pin_inf_res", r, 32'h7F800000); chk("pin_inf_lat", l, 2);
    model(32'h00000000, 32'hC0400000, r, l, k);
    chk("pin_zero_res", r, 32'hC0400000);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, consumer always ready.
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000);
    send(32'h3F800000, 32'hBF800000);
    send(32'h3FC00000, 32'hBF800000);
    send(32'h7F7FFFFF, 32'h7F7FFFFF);
    send(32'h7F800000, 32'h3F800000);
    send(32'h80000000, 32'h80000000);
    send(32'h00800001, 32'h80800000);
    send(32'h3F800001, 32'hBF800000);
    wait_idle();

    // Stall in DONE with a new pair offered; release together with a fresh pair.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000);
    l = 0;
    while (!out_valid && l < 50) begin @(negedge clk); l++; end
    chk("hold_reached_done", {31'b0, out_valid}, 32'h1);
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
    end
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40000000;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    chk("hold_followup_res", result, 32'h40400000);

    // Reset during NORM of a long left-normalization.
    send(32'h3F800001, 32'hBF800000);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'h0);
    chk("async_busy",      {31'b0, busy},      32'h0);
    chk("async_result",    result,             32'h0);
    chk("async_in_ready",  {31'b0, in_ready},  32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    send(32'h3F800000, 32'h3F800000);
    wait_idle();
    chk("post_rst_res", result, 32'h40000000);

    // Randomized traffic with a randomly stalling consumer.
    ordy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      kx = int'($urandom_range(0, 4));
      if (kx == 1) kx = 0;
      x = gen_op(32'h0, kx);
      y = gen_op(x, int'($urandom_range(0, 4)));
      send(x, y);
    end
    ordy_rand = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
